// File: rtl/alt_vipvfr130_prc_seq_pkg.sv
// Shared definitions for the PRC frame sequencer.
// Contents: PRC slave register indices, packet type codes, control and
// interrupt bit masks, the FSM state encoding, the control packet size
// functions, and the helper that gives the bit width a value needs.
package alt_vipvfr130_prc_seq_pkg;

    // PRC Avalon-MM slave register indices
    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_IRQ       = 3'd2;
    localparam logic [2:0] REG_PKT_ADDR  = 3'd3;
    localparam logic [2:0] REG_PKT_TYPE  = 3'd4;
    localparam logic [2:0] REG_PKT_SAMP  = 3'd5;
    localparam logic [2:0] REG_PKT_WORDS = 3'd6;

    // Packet type codes
    localparam logic [31:0] TYPE_VIDEO = 32'd0;
    localparam logic [31:0] TYPE_CTRL  = 32'd15;

    // Register bit masks
    localparam logic [31:0] CTRL_GO      = 32'h1;
    localparam logic [31:0] CTRL_IRQ_EN  = 32'h2;
    localparam logic [31:0] IRQ_COMPLETE = 32'h2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LATCH,
        ST_MUL,
        ST_DIV,
        ST_CHECK,
        ST_WR_ADDR,
        ST_WR_TYPE,
        ST_WR_SAMP,
        ST_WR_WORDS,
        ST_WR_GO,
        ST_WAIT_IRQ,
        ST_WR_CLR,
        ST_DONE
    } state_t;

    // A control packet carries 9 symbols spread over the parallel channels
    function automatic int ctrl_samples(input int channels_in_par);
        return (9 + channels_in_par - 1) / channels_in_par;
    endfunction

    function automatic int ctrl_words(input int channels_in_par, input int samples_per_word);
        return (ctrl_samples(channels_in_par) + samples_per_word - 1) / samples_per_word;
    endfunction

    // Number of bits needed to hold value v (at least 1)
    function automatic int req_width(input longint v);
        int n;
        n = 1;
        for (int i = 0; i < 63; i++) begin
            if ((v >> i) != 0) n = i + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/alt_vipvfr130_prc_seq_divider.sv
// Restoring divider by a constant, one quotient bit per cycle, with a
// ceiling result.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          load i_dividend and begin; takes SW cycles
//   i_dividend       SW-bit unsigned dividend
//   o_last           high during the final iteration cycle; o_ceil is valid
//                    from the following cycle until the next i_start
//   o_ceil           ceil(dividend / DIVISOR)
module alt_vipvfr130_prc_seq_divider #(
    parameter int SW      = 21,
    parameter int DIVISOR = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [SW-1:0] i_dividend,
    output logic          o_last,
    output logic [SW-1:0] o_ceil
);
    localparam int CW = $clog2(SW + 1);
    localparam logic [SW:0] DIV_EXT = (SW+1)'(DIVISOR);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_quo;
    logic [SW-1:0] r_rem;
    logic [SW:0]   w_rem_sh;
    logic          w_ge;

    // The dividend shifts out of r_quo MSB-first while quotient bits shift in
    assign w_rem_sh = {r_rem, r_quo[SW-1]};
    assign w_ge     = (w_rem_sh >= DIV_EXT);
    assign o_last   = r_busy && (r_cnt == CW'(SW - 1));
    assign o_ceil   = r_quo + SW'(r_rem != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + CW'(1);
            if (o_last) r_busy <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
        end else if (r_busy) begin
            r_quo <= {r_quo[SW-2:0], w_ge};
            // remainder stays below DIVISOR, so the low SW bits are exact
            r_rem <= w_ge ? SW'(w_rem_sh - DIV_EXT) : w_rem_sh[SW-1:0];
        end
    end

endmodule

// File: rtl/alt_vipvfr130_prc_sequencer.sv
// Frame sequencer driving the PRC control slave as a write-only master.
// Per frame: latch configuration, compute sample and word counts, range
// check, optionally program a control packet, then the video packet
// (addr, type, samples, words, GO), wait for the completion interrupt,
// clear it, and repeat while cfg_go stays high.
// Ports:
//   clock, reset         clock, asynchronous active-low reset
//   cfg_*                frame configuration, latched once per frame
//   prc_av_*             Avalon-MM write master into the PRC slave, plus irq
//   busy                 state is not IDLE
//   frame_done/error     one-cycle pulses per completed / skipped frame
//   frame_count          completed frames, wrapping
module alt_vipvfr130_prc_sequencer
    import alt_vipvfr130_prc_seq_pkg::*;
#(
    parameter int BPS             = 8,
    parameter int CHANNELS_IN_PAR = 3,
    parameter int CHANNELS_IN_SEQ = 1,
    parameter int MEM_PORT_WIDTH  = 256,
    parameter int MAX_WIDTH       = 1920,
    parameter int MAX_HEIGHT      = 1080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfg_go,
    input  logic        cfg_send_ctrl,
    input  logic [31:0] cfg_frame_addr,
    input  logic [31:0] cfg_ctrl_addr,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_height,
    output logic [2:0]  prc_av_address,
    output logic        prc_av_write,
    output logic [31:0] prc_av_writedata,
    input  logic        prc_av_irq,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_error,
    output logic [15:0] frame_count
);
    localparam int SAMPLES_PER_WORD = MEM_PORT_WIDTH / (BPS * CHANNELS_IN_PAR);
    localparam int SW = req_width(longint'(MAX_WIDTH) * longint'(MAX_HEIGHT) * longint'(CHANNELS_IN_SEQ));
    localparam logic [31:0] CTRL_SAMPLES = 32'(ctrl_samples(CHANNELS_IN_PAR));
    localparam logic [31:0] CTRL_WORDS   = 32'(ctrl_words(CHANNELS_IN_PAR, SAMPLES_PER_WORD));

    state_t        r_state, w_state_nxt;
    logic          r_ctrl_phase, w_ctrl_nxt;
    logic          r_send_ctrl;
    logic [31:0]   r_frame_addr, r_ctrl_addr;
    logic [15:0]   r_width, r_height;
    logic [SW-1:0] r_samples;
    logic [SW-1:0] w_samples;
    logic [SW-1:0] w_words;
    logic          w_div_last;
    logic          w_bad;

    logic          r_write, w_write;
    logic [2:0]    r_addr, w_addr;
    logic [31:0]   r_data, w_data;
    logic          r_done, r_err, w_err;
    logic [15:0]   r_count;

    assign w_samples = SW'(r_width) * SW'(r_height) * SW'(CHANNELS_IN_SEQ);
    assign w_bad = (r_width == '0) || (r_height == '0) ||
                   (r_width > 16'(MAX_WIDTH)) || (r_height > 16'(MAX_HEIGHT));

    alt_vipvfr130_prc_seq_divider #(
        .SW      (SW),
        .DIVISOR (SAMPLES_PER_WORD)
    ) u_div (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_start    (r_state == ST_MUL),
        .i_dividend (w_samples),
        .o_last     (w_div_last),
        .o_ceil     (w_words)
    );

    // Frame configuration and product, captured once per frame
    always_ff @(posedge clock) begin
        if (r_state == ST_LATCH) begin
            r_send_ctrl  <= cfg_send_ctrl;
            r_frame_addr <= cfg_frame_addr;
            r_ctrl_addr  <= cfg_ctrl_addr;
            r_width      <= cfg_width;
            r_height     <= cfg_height;
        end
        if (r_state == ST_MUL) r_samples <= w_samples;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_ctrl_phase <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ctrl_phase <= w_ctrl_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_nxt  = r_ctrl_phase;
        unique case (r_state)
            ST_IDLE:     if (cfg_go) w_state_nxt = ST_LATCH;
            ST_LATCH:    w_state_nxt = ST_MUL;
            ST_MUL:      w_state_nxt = ST_DIV;
            ST_DIV:      if (w_div_last) w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (w_bad) begin
                    w_state_nxt = cfg_go ? ST_LATCH : ST_IDLE;
                end else begin
                    w_state_nxt = ST_WR_ADDR;
                    w_ctrl_nxt  = r_send_ctrl;
                end
            end
            ST_WR_ADDR:  w_state_nxt = ST_WR_TYPE;
            ST_WR_TYPE:  w_state_nxt = ST_WR_SAMP;
            ST_WR_SAMP:  w_state_nxt = ST_WR_WORDS;
            ST_WR_WORDS: w_state_nxt = ST_WR_GO;
            ST_WR_GO:    w_state_nxt = ST_WAIT_IRQ;
            ST_WAIT_IRQ: if (prc_av_irq) w_state_nxt = ST_WR_CLR;
            ST_WR_CLR: begin
                if (r_ctrl_phase) begin
                    w_state_nxt = ST_WR_ADDR;
                    w_ctrl_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:     w_state_nxt = cfg_go ? ST_LATCH : ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered bus lines
    // up with the state that issues each write.
    always_comb begin
        w_write = 1'b0;
        w_addr  = r_addr;
        w_data  = r_data;
        w_err   = (r_state == ST_CHECK) && w_bad;
        unique case (w_state_nxt)
            ST_WR_ADDR: begin
                w_write = 1'b1;
                w_addr  = REG_PKT_ADDR;
                w_data  = w_ctrl_nxt ? r_ctrl_addr : r_frame_addr;
            end
            ST_WR_TYPE: begin
                w_write = 1'b1;
                w_addr  = REG_PKT_TYPE;
                w_data  = w_ctrl_nxt ? TYPE_CTRL : TYPE_VIDEO;
            end
            ST_WR_SAMP: begin
                w_write = 1'b1;
                w_addr  = REG_PKT_SAMP;
                w_data  = w_ctrl_nxt ? CTRL_SAMPLES : 32'(r_samples);
            end
            ST_WR_WORDS: begin
                w_write = 1'b1;
                w_addr  = REG_PKT_WORDS;
                w_data  = w_ctrl_nxt ? CTRL_WORDS : 32'(w_words);
            end
            ST_WR_GO: begin
                w_write = 1'b1;
                w_addr  = REG_CTRL;
                w_data  = CTRL_GO | CTRL_IRQ_EN;
            end
            ST_WR_CLR: begin
                w_write = 1'b1;
                w_addr  = REG_IRQ;
                w_data  = IRQ_COMPLETE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_write <= w_write;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_done  <= (w_state_nxt == ST_DONE);
            r_err   <= w_err;
            r_count <= r_count + 16'(w_state_nxt == ST_DONE);
        end
    end

    assign prc_av_write     = r_write;
    assign prc_av_address   = r_addr;
    assign prc_av_writedata = r_data;
    assign frame_done       = r_done;
    assign frame_error      = r_err;
    assign frame_count      = r_count;
    assign busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alt_vipvfr130_prc_sequencer.sv
module tb_alt_vipvfr130_prc_sequencer;
    localparam int SW     = 21;   // bits for 1920*1080
    localparam int SPW    = 10;   // 256 / (8*3)
    localparam int CIP    = 3;
    localparam int CIS    = 1;
    localparam int MAXW   = 1920;
    localparam int MAXH   = 1080;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_go = 1'b0;
    logic        cfg_send_ctrl = 1'b0;
    logic [31:0] cfg_frame_addr = '0;
    logic [31:0] cfg_ctrl_addr = '0;
    logic [15:0] cfg_width = '0;
    logic [15:0] cfg_height = '0;
    logic [2:0]  prc_av_address;
    logic        prc_av_write;
    logic [31:0] prc_av_writedata;
    logic        prc_av_irq = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        frame_error;
    logic [15:0] frame_count;

    always #5 clock = ~clock;

    alt_vipvfr130_prc_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .cfg_go           (cfg_go),
        .cfg_send_ctrl    (cfg_send_ctrl),
        .cfg_frame_addr   (cfg_frame_addr),
        .cfg_ctrl_addr    (cfg_ctrl_addr),
        .cfg_width        (cfg_width),
        .cfg_height       (cfg_height),
        .prc_av_address   (prc_av_address),
        .prc_av_write     (prc_av_write),
        .prc_av_writedata (prc_av_writedata),
        .prc_av_irq       (prc_av_irq),
        .busy             (busy),
        .frame_done       (frame_done),
        .frame_error      (frame_error),
        .frame_count      (frame_count)
    );

    typedef struct { int cyc; logic [2:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [2:0] a; logic [31:0] d; } ex_t;
    typedef struct { int w; int h; bit ctrl; bit bad; int samp; int words; } vec_t;

    wr_t wq[$];
    ex_t eq[$];
    int  cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;
    int irq_delay = 0, cnt = 0;
    bit pend = 0;
    int irq_cyc = -1, go_cyc = -1, clr_cyc = -1, done_cyc = -1;
    int n_done = 0, n_err = 0, n_go = 0;
    int exp_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock: monitor the bus at the falling edge and play the PRC side
    task automatic step();
        wr_t e;
        @(negedge clock);
        if (prc_av_write) begin
            e.cyc = cyc; e.a = prc_av_address; e.d = prc_av_writedata;
            wq.push_back(e);
            if (prc_av_address == 3'd2) begin
                clr_cyc = cyc;
                if (irq_cyc >= 0) chk("clr_latency", cyc, irq_cyc + 1);
                prc_av_irq = 1'b0;
                irq_cyc = -1;
            end
            if (prc_av_address == 3'd0) begin
                go_cyc = cyc; n_go++; pend = 1; cnt = irq_delay;
            end
        end else if (pend) begin
            if (cnt == 0) begin
                prc_av_irq = 1'b1; irq_cyc = cyc; pend = 0;
            end else begin
                cnt--;
            end
        end
        if (frame_done) begin n_done++; done_cyc = cyc; end
        if (frame_error) n_err++;
    endtask

    // Reference: what a frame should put on the bus, from the packet rules
    function automatic void model(input int w, input int h, output int samp, output int words, output bit bad);
        bad   = (w == 0) || (h == 0) || (w > MAXW) || (h > MAXH);
        samp  = w * h * CIS;
        words = (samp + SPW - 1) / SPW;
    endfunction

    function automatic void push_pkt(input logic [31:0] addr, input int ptype, input int samp, input int words);
        ex_t x;
        x.a = 3'd3; x.d = addr;          eq.push_back(x);
        x.a = 3'd4; x.d = 32'(ptype);    eq.push_back(x);
        x.a = 3'd5; x.d = 32'(samp);     eq.push_back(x);
        x.a = 3'd6; x.d = 32'(words);    eq.push_back(x);
        x.a = 3'd0; x.d = 32'h3;         eq.push_back(x);
        x.a = 3'd2; x.d = 32'h2;         eq.push_back(x);
    endfunction

    function automatic void expect_frame(input bit ctrl, input logic [31:0] fa, input logic [31:0] ca,
                                         input int samp, input int words, input bit bad);
        if (!bad) begin
            if (ctrl) push_pkt(ca, 15, (9 + CIP - 1) / CIP, ((9 + CIP - 1) / CIP + SPW - 1) / SPW);
            push_pkt(fa, 0, samp, words);
        end
    endfunction

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, wq.size(), eq.size());
        for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wq[i].a, eq[i].a);
            chk($sformatf("%s_data%0d", tag, i), wq[i].d, eq[i].d);
        end
        if (wq.size() == eq.size())
            for (int k = 0; k + 4 < wq.size(); k += 6)
                chk($sformatf("%s_b2b%0d", tag, k), wq[k+4].cyc - wq[k].cyc, 4);
    endtask

    task automatic run_frame(input int w, input int h, input bit ctrl, input logic [31:0] fa,
                             input logic [31:0] ca, input int dly, output int c0, output bit tmo);
        wq.delete(); eq.delete();
        n_done = 0; n_err = 0; n_go = 0; irq_delay = dly;
        cfg_width = 16'(w); cfg_height = 16'(h); cfg_send_ctrl = ctrl;
        cfg_frame_addr = fa; cfg_ctrl_addr = ca;
        cfg_go = 1'b1; c0 = cyc;
        step();
        cfg_go = 1'b0;
        tmo = 1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (n_done + n_err > 0) begin tmo = 0; break; end
        end
        repeat (3) step();
    endtask

    vec_t vt[8];

    initial begin
        int c0, samp, words, d1;
        bit tmo, bad, found;
        logic [31:0] fa, ca;

        vt[0] = '{1920, 1080, 1'b0, 1'b0, 2073600, 207360};
        vt[1] = '{  11,    1, 1'b1, 1'b0,      11,      2};
        vt[2] = '{   0,    5, 1'b0, 1'b1,       0,      0};
        vt[3] = '{1921,   10, 1'b0, 1'b1,       0,      0};
        vt[4] = '{  10, 1081, 1'b1, 1'b1,       0,      0};
        vt[5] = '{   1,    1, 1'b0, 1'b0,       1,      1};
        vt[6] = '{  20,    1, 1'b1, 1'b0,      20,      2};
        vt[7] = '{1920, 1080, 1'b1, 1'b0, 2073600, 207360};

        // Reset state
        repeat (3) step();
        chk("rst_write", prc_av_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {frame_done, frame_error}, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_bus", {prc_av_address, prc_av_writedata}, 0);
        reset = 1'b1;
        repeat (2) step();
        chk("idle_busy", busy, 0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            fa = 32'h1000_0000 + 32'(i) * 32'h100;
            ca = 32'h2000_0000 + 32'(i);
            run_frame(vt[i].w, vt[i].h, vt[i].ctrl, fa, ca, 3, c0, tmo);
            chk($sformatf("t%0d_timeout", i), tmo, 0);
            expect_frame(vt[i].ctrl, fa, ca, vt[i].samp, vt[i].words, vt[i].bad);
            check_writes($sformatf("t%0d", i));
            chk($sformatf("t%0d_done", i), n_done, !vt[i].bad);
            chk($sformatf("t%0d_err", i), n_err, vt[i].bad);
            if (!vt[i].bad) exp_count++;
            chk($sformatf("t%0d_count", i), frame_count, exp_count);
            chk($sformatf("t%0d_busy", i), busy, 0);
            if (!vt[i].bad) begin
                chk($sformatf("t%0d_done_lat", i), done_cyc, clr_cyc + 1);
                chk($sformatf("t%0d_ngo", i), n_go, vt[i].ctrl ? 2 : 1);
                if (wq.size() > 0) chk($sformatf("t%0d_first_wr", i), wq[0].cyc, c0 + SW + 4);
            end
        end

        // Interrupt held off for 1000 cycles
        run_frame(20, 2, 1'b0, 32'hABCD_0000, 32'h0, 1000, c0, tmo);
        chk("hold_timeout", tmo, 0);
        model(20, 2, samp, words, bad);
        expect_frame(1'b0, 32'hABCD_0000, 32'h0, samp, words, bad);
        check_writes("hold");
        chk("hold_window", clr_cyc - go_cyc, 1002);
        exp_count++;
        chk("hold_count", frame_count, exp_count);

        // Three back-to-back frames, cfg_go dropped during the third
        wq.delete(); eq.delete();
        n_done = 0; n_err = 0; n_go = 0; irq_delay = 4; d1 = -1;
        cfg_width = 16'd8; cfg_height = 16'd2; cfg_send_ctrl = 1'b0;
        cfg_frame_addr = 32'h5555_0000; cfg_go = 1'b1;
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (n_done == 1 && d1 < 0) d1 = done_cyc;
            if (n_go == 3 && cfg_go) cfg_go = 1'b0;
            if (n_done == 3) begin found = 1; break; end
        end
        cfg_go = 1'b0;
        repeat (5) step();
        chk("multi_timeout", found, 1);
        model(8, 2, samp, words, bad);
        repeat (3) expect_frame(1'b0, 32'h5555_0000, 32'h0, samp, words, bad);
        check_writes("multi");
        chk("multi_done", n_done, 3);
        exp_count += 3;
        chk("multi_count", frame_count, exp_count);
        chk("multi_busy", busy, 0);
        if (wq.size() > 6) chk("multi_relatch", wq[6].cyc, d1 + SW + 4);

        // Reset asserted during the samples write
        wq.delete();
        cfg_width = 16'd1920; cfg_height = 16'd1080; irq_delay = 2;
        cfg_go = 1'b1;
        step();
        cfg_go = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (wq.size() > 0 && wq[wq.size()-1].a == 3'd5 && prc_av_write) begin found = 1; break; end
        end
        chk("rstmid_reached", found, 1);
        reset = 1'b0;
        #1;
        chk("rstmid_write", prc_av_write, 0);
        chk("rstmid_bus", {prc_av_address, prc_av_writedata}, 0);
        chk("rstmid_flags", {busy, frame_done, frame_error}, 0);
        chk("rstmid_count", frame_count, 0);
        pend = 0; prc_av_irq = 1'b0; irq_cyc = -1;
        repeat (2) step();
        reset = 1'b1;
        wq.delete();
        repeat (20) step();
        chk("rstmid_idle_wr", wq.size(), 0);
        chk("rstmid_idle_busy", busy, 0);
        exp_count = 0;

        // Randomized frames against the reference model
        for (int i = 0; i < 8; i++) begin
            int w, h, r, dly;
            bit ctrl;
            r = $urandom_range(0, 9);
            if (r == 0) w = 0;
            else if (r == 1) w = MAXW + 1;
            else w = $urandom_range(1, 40);
            h = $urandom_range(1, 6);
            ctrl = 1'($urandom_range(0, 1));
            fa = $urandom; ca = $urandom;
            dly = $urandom_range(0, 6);
            run_frame(w, h, ctrl, fa, ca, dly, c0, tmo);
            chk($sformatf("r%0d_timeout", i), tmo, 0);
            model(w, h, samp, words, bad);
            expect_frame(ctrl, fa, ca, samp, words, bad);
            check_writes($sformatf("r%0d", i));
            chk($sformatf("r%0d_err", i), n_err, bad);
            chk($sformatf("r%0d_done", i), n_done, !bad);
            if (!bad) exp_count++;
            chk($sformatf("r%0d_count", i), frame_count, exp_count);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
